// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: bit positions, all-on/all-off patterns and
// the active-high glyph table, plus the lookup/priority function used by the decoder.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_ALL_ON  = 7'h7F;
  localparam logic [6:0] SEG_ALL_OFF = 7'h00;

  // Active-high lit pattern (gfedcba), indexed by digit value 0..F.
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Priority is lamp_test > blank > digit; letters 10..15 show only when hex_en.
  function automatic logic [6:0] seg_pattern(
    input logic [3:0] digit,
    input logic       blank,
    input logic       lamp_test,
    input logic       hex_en
  );
    logic [6:0] pat_s;
    pat_s = SEG_ALL_OFF;
    if (lamp_test) begin
      pat_s = SEG_ALL_ON;
    end else if (blank) begin
      pat_s = SEG_ALL_OFF;
    end else begin
      case (digit)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
        4'd5, 4'd6, 4'd7, 4'd8, 4'd9:    pat_s = SEG_TABLE[digit];
        4'd10, 4'd11, 4'd12, 4'd13,
        4'd14, 4'd15:                    pat_s = hex_en ? SEG_TABLE[digit] : SEG_ALL_OFF;
        default:                         pat_s = SEG_ALL_OFF;
      endcase
    end
    return pat_s;
  endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// Registered single-digit 7-segment cathode decoder with blanking, lamp test
// and board-selectable output polarity. One clock of latency, no comb path to seg.
module seg7_digit_decoder
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1,
  parameter int HEX_EN     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] seg
);

  // XOR mask that turns an active-high pattern into the board's drive levels.
  localparam logic [6:0] POL_MASK  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0] OFF_LEVEL = SEG_ALL_OFF ^ POL_MASK;
  localparam logic       HEX_ON    = (HEX_EN != 0) ? 1'b1 : 1'b0;

  logic [6:0] seg_next_s;
  logic [6:0] seg_r;

  // Lookup with priority, then apply output polarity.
  always_comb begin
    seg_next_s = OFF_LEVEL;
    seg_next_s = seg_pattern(digit, blank, lamp_test, HEX_ON) ^ POL_MASK;
  end

  // Output register; reset forces all segments dark without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= OFF_LEVEL;
    end else begin
      seg_r <= seg_next_s;
    end
  end

  assign seg = seg_r;

endmodule

// File: tb/tb_seg7_digit_decoder.sv
// Directed self-checking bench: active-low hex, active-low decimal-only and
// active-high instances share one stimulus stream.
module tb_seg7_digit_decoder;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [3:0] digit;
  logic       blank;
  logic       lamp_test;
  logic [6:0] seg_lo;
  logic [6:0] seg_dec;
  logic [6:0] seg_hi;

  int n_checks;
  int n_errors;

  // Hand-written active-high glyphs (gfedcba) for 0..F.
  logic [6:0] exp_tab [0:15];

  seg7_digit_decoder #(.ACTIVE_LOW(1), .HEX_EN(1)) u_lo (
    .clk(clk), .rst(rst), .digit(digit), .blank(blank),
    .lamp_test(lamp_test), .seg(seg_lo)
  );

  seg7_digit_decoder #(.ACTIVE_LOW(1), .HEX_EN(0)) u_dec (
    .clk(clk), .rst(rst), .digit(digit), .blank(blank),
    .lamp_test(lamp_test), .seg(seg_dec)
  );

  seg7_digit_decoder #(.ACTIVE_LOW(0), .HEX_EN(1)) u_hi (
    .clk(clk), .rst(rst), .digit(digit), .blank(blank),
    .lamp_test(lamp_test), .seg(seg_hi)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 7'b%b expected 7'b%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] dec_exp;
    n_checks  = 0;
    n_errors  = 0;
    exp_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    clk_en    = 1'b0;
    rst       = 1'b1;
    digit     = 4'd0;
    blank     = 1'b0;
    lamp_test = 1'b0;

    // Reset with no clock running.
    #2;
    check_eq("rst_lo",  seg_lo,  7'b1111111);
    check_eq("rst_dec", seg_dec, 7'b1111111);
    check_eq("rst_hi",  seg_hi,  7'b0000000);

    clk_en = 1'b1;
    #1;
    rst   = 1'b0;
    digit = 4'd8;
    #1;
    check_eq("no_comb_path", seg_lo, 7'b1111111);
    tick();
    check_eq("first_8_lo", seg_lo, 7'b0000000);
    check_eq("first_8_hi", seg_hi, 7'b1111111);

    // Full sweep, one new digit per edge.
    for (int i = 0; i < 16; i++) begin
      digit = i[3:0];
      tick();
      dec_exp = (i < 10) ? exp_tab[i] : 7'h00;
      check_eq($sformatf("sweep_lo_%0d", i),  seg_lo,  ~exp_tab[i]);
      check_eq($sformatf("sweep_dec_%0d", i), seg_dec, ~dec_exp);
      check_eq($sformatf("sweep_hi_%0d", i),  seg_hi,  exp_tab[i]);
      if (i == 0)  check_eq("lit_0",  seg_lo, 7'b1000000);
      if (i == 1)  check_eq("lit_1",  seg_lo, 7'b1111001);
      if (i == 15) check_eq("lit_F",  seg_lo, 7'b0001110);
    end

    // Decimal-only instance boundary cases.
    digit = 4'd9;
    tick();
    check_eq("dec_9",  seg_dec, 7'b0010000);
    digit = 4'd12;
    tick();
    check_eq("dec_12", seg_dec, 7'b1111111);

    // Priority: blank over digit, lamp_test over blank.
    digit = 4'd5;
    blank = 1'b1;
    tick();
    check_eq("blank_lo", seg_lo, 7'b1111111);
    check_eq("blank_hi", seg_hi, 7'b0000000);
    lamp_test = 1'b1;
    tick();
    check_eq("lamp_lo", seg_lo, 7'b0000000);
    check_eq("lamp_hi", seg_hi, 7'b1111111);
    lamp_test = 1'b0;
    blank     = 1'b0;
    tick();
    check_eq("resume_5", seg_lo, 7'b0010010);

    // Active-high instance, digit 2.
    digit = 4'd2;
    tick();
    check_eq("hi_2", seg_hi, 7'b1011011);

    // Mid-stream asynchronous reset pulse between edges.
    digit = 4'd3;
    tick();
    check_eq("stream_3", seg_lo, ~7'h4F);
    digit = 4'd4;
    tick();
    check_eq("stream_4", seg_lo, ~7'h66);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_lo", seg_lo, 7'b1111111);
    check_eq("mid_rst_hi", seg_hi, 7'b0000000);
    rst   = 1'b0;
    digit = 4'd5;
    #1;
    check_eq("hold_off_lo", seg_lo, 7'b1111111);
    tick();
    check_eq("post_rst_5", seg_lo, 7'b0010010);
    check_eq("post_rst_hi", seg_hi, 7'h6D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_digit_decoder.md
Name: seg7_digit_decoder

Overview:
- Registered 4-bit-to-7-segment decoder for a single digit.
- Sits under the 4-digit multiplexed display driver, which time-slices the units, tens, hundreds and thousands nibbles into `digit` and drives the anodes itself.
- This block owns only the segment cathode pattern for the currently selected nibble.
- Adds blanking, lamp test and selectable output polarity so the same block serves active-low and active-high boards.

Parameters:
- ACTIVE_LOW, 1: 1 = lit segment driven 0 (common-anode boards); 0 = lit segment driven 1.
- HEX_EN, 1: 1 = codes 10–15 render A, b, C, d, E, F; 0 = codes 10–15 render blank.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- digit  in  4  binary value to display, 0–15.
- blank  in  1  1 = all segments off; overrides digit.
- lamp_test  in  1  1 = all segments lit; overrides blank and digit.
- seg  out  7  segment drive, bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g; polarity per ACTIVE_LOW.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- While rst=1, seg = all segments off: 7'b1111111 if ACTIVE_LOW=1, 7'b0000000 if ACTIVE_LOW=0. This holds immediately, with no clock edge needed.
- After reset release, seg is a registered function of the inputs. Latency is exactly 1 clk: inputs sampled at edge N appear on seg after edge N. No combinational input-to-output path.
- Priority each edge, highest first: lamp_test (pattern 0x7F) > blank (0x00) > digit decode.
- Active-high lit patterns (gfedcba) per digit:
  - 0 → 0x3F, 1 → 0x06, 2 → 0x5B, 3 → 0x4F
  - 4 → 0x66, 5 → 0x6D, 6 → 0x7D, 7 → 0x07
  - 8 → 0x7F, 9 → 0x6F
- Codes 10–15 with HEX_EN=1: A → 0x77, b → 0x7C, C → 0x39, d → 0x5E, E → 0x79, F → 0x71.
- Codes 10–15 with HEX_EN=0: 0x00 (blank).
- Output polarity: seg = pattern if ACTIVE_LOW=0; seg = ~pattern if ACTIVE_LOW=1.
- If rst asserts mid-operation, seg goes to off asynchronously. The first decode after release is taken at the first clk edge with rst=0.
- If digit changes every cycle, seg follows every cycle. There is no hold or debounce.
- X/unknown digit values must not occur. Any encoding not covered above (none exists for 4 bits) is not a concern, but the case statement has a default of blank.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry active-high segment pattern constant table (index = digit);
  - named constants SEG_ALL_ON = 7'h7F and SEG_ALL_OFF = 7'h00;
  - the bit-index constants SEG_A..SEG_G.
- No sub-module. The block is:
  - a combinational lookup/priority stage (a function in seg7_pkg);
  - a polarity XOR;
  - a single 7-bit output register with async reset.

Test Plan:
- Reset: assert rst with no clock running → seg = 7'b1111111 immediately (ACTIVE_LOW=1). Release, then apply digit=8 → seg = 7'b0000000 one edge later.
- Full sweep, ACTIVE_LOW=1, HEX_EN=1: digit 0..15 on consecutive edges → each pattern is the inverse of the table, one cycle late.
  - digit 0 → 7'b1000000
  - digit 1 → 7'b1111001
  - digit F → 7'b0001110
- HEX_EN=0 instance: digit=9 → active-high 0x6F inverted (7'b0010000); digit=12 → 7'b1111111 (blank).
- Priority: digit=5 with blank=1 → all off. Then lamp_test=1 with blank=1 → all on (7'b0000000, active-low). Then lamp_test=0, blank=0 → 5 pattern (7'b0010010).
- ACTIVE_LOW=0 instance: digit=2 → seg = 7'b1011011. Reset → 7'b0000000.
- Mid-stream reset: stream digits 3,4,5 and pulse rst between clock edges → seg goes to off asynchronously. The next edge after release shows the current digit.
